// File: rtl/regfile_write_bank_if.sv
// Write-back port bundle of the integer register file: write request in,
// full register array and last-write one-hot out.
interface regfile_write_bank_if #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
);
    logic                     RegWrite;
    logic [4:0]               WriteRegister;
    logic [WIDTH-1:0]         WriteData;
    logic [WIDTH-1:0]         regs [NREGS];
    logic [NREGS-1:0]         wr_onehot;

    // WB stage side: issues writes, observes the array.
    modport master (
        output RegWrite, WriteRegister, WriteData,
        input  regs, wr_onehot
    );

    // Register file side: accepts writes, exports the array.
    modport slave (
        input  RegWrite, WriteRegister, WriteData,
        output regs, wr_onehot
    );
endinterface

// File: rtl/regfile_write_bank.sv
// Storage and write side of the ARM64 integer register file.
// X0-X30 are 64-bit registers written from the WB stage; X31 (XZR) reads as zero
// and silently discards writes. There is no write-to-read bypass: a written value
// appears on regs after the clock edge, and hazards are left to forwarding.
module regfile_write_bank #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_bank_if.slave   bus
);
    localparam int XZR = NREGS - 1;

    logic [WIDTH-1:0] r_regs [XZR];
    logic [NREGS-1:0] r_onehot;
    logic [NREGS-1:0] w_dec;
    logic [NREGS-1:0] w_wr_en;

    // Decode the destination into a one-hot write enable, gated by RegWrite; XZR bit masked.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_dec = '0;
        // The address is only looked at when RegWrite is set, so an unknown Rd on idle cycles cannot reach state.
        if (bus.RegWrite) begin
            w_dec[bus.WriteRegister] = 1'b1;
        end
        w_wr_en      = w_dec;
        w_wr_en[XZR] = 1'b0;
    end

    // Register array and last-write one-hot; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: this array is architectural state that must read zero after reset, so unlike a RAM it is cleared.
            for (int i = 0; i < XZR; i++) begin
                r_regs[i] <= '0;
            end
            r_onehot <= '0;
        end else begin
            for (int i = 0; i < XZR; i++) begin
                if (w_wr_en[i]) begin
                    r_regs[i] <= bus.WriteData;
                end
            end
            r_onehot <= w_wr_en;
        end
    end

    // Export the array with XZR tied to zero.
    always_comb begin
        for (int i = 0; i < XZR; i++) begin
            bus.regs[i] = r_regs[i];
        end
        bus.regs[XZR] = '0;
    end

    assign bus.wr_onehot = r_onehot;
endmodule
